// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format enum,
// major-opcode constants and the buffered entry record.
package imm_gen_pkg;

  localparam int XLEN_MAX = 64;

  // C.B* reports FMT_B; is_rel still marks it as a branch target.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CI   = 3'd6,
    FMT_CJ   = 3'd7
  } imm_fmt_t;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  localparam logic [2:0] C_F3_ADDI = 3'b000;
  localparam logic [2:0] C_F3_LI   = 3'b010;
  localparam logic [2:0] C_F3_LUI  = 3'b011;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // Fields are sized for the widest XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_t            fmt;
    logic                is_rel;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode: instruction word + PC -> entry record.
// RVC_EN adds quadrant-01 compressed decode; otherwise compressed is illegal.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output entry_t          ent_o
);

  localparam bit OPIMM32_EN = (XLEN == 64) && (RV64_OPS != 0);

  logic [63:0]     imm;
  imm_fmt_t        fmt;
  logic            rel;
  logic            ill;
  logic [XLEN-1:0] tgt;

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    rel = 1'b0;
    ill = 1'b0;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:2])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          imm = {{52{instr_i[31]}}, instr_i[31:20]};
          fmt = FMT_I;
        end
        OPC_OP_IMM32: begin
          if (OPIMM32_EN) begin
            imm = {{52{instr_i[31]}}, instr_i[31:20]};
            fmt = FMT_I;
          end else begin
            ill = 1'b1;
          end
        end
        OPC_STORE: begin
          imm = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          fmt = FMT_S;
        end
        OPC_BRANCH: begin
          imm = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
          fmt = FMT_B;
          rel = 1'b1;
        end
        OPC_JAL: begin
          imm = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
          fmt = FMT_J;
          rel = 1'b1;
        end
        OPC_AUIPC, OPC_LUI: begin
          imm = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
          fmt = FMT_U;
          rel = (instr_i[6:2] == OPC_AUIPC);
        end
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef RVC_EN
      if (instr_i[1:0] == 2'b01) begin
        case (instr_i[15:13])
          C_F3_ADDI, C_F3_LI: begin
            imm = {{58{instr_i[12]}}, instr_i[12], instr_i[6:2]};
            fmt = FMT_CI;
          end
          C_F3_LUI: begin
            // rd=0 is reserved, rd=2 is C.ADDI16SP (not decoded here)
            if (instr_i[11:7] == 5'd0 || instr_i[11:7] == 5'd2) begin
              ill = 1'b1;
            end else begin
              imm = {{46{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'b0};
              fmt = FMT_CI;
            end
          end
          C_F3_J: begin
            imm = {{52{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                   instr_i[6], instr_i[7], instr_i[2], instr_i[11],
                   instr_i[5:3], 1'b0};
            fmt = FMT_CJ;
            rel = 1'b1;
          end
          C_F3_BEQZ, C_F3_BNEZ: begin
            imm = {{55{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                   instr_i[11:10], instr_i[4:3], 1'b0};
            fmt = FMT_B;
            rel = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end else begin
        ill = 1'b1;
      end
`else
      ill = 1'b1;
`endif
    end
  end

  assign tgt = pc_i + imm[XLEN-1:0];

  always_comb begin
    ent_o                  = '0;
    ent_o.imm              = imm;
    ent_o.fmt              = fmt;
    ent_o.is_rel           = rel;
    ent_o.illegal          = ill;
    ent_o.target[XLEN-1:0] = tgt;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeding a 2-entry in-order skid buffer.
// Optional RVC_EN macro enables compressed quadrant-01 decode in imm_decode.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_is_rel,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  buf_state_t state_q, state_d;
  entry_t     head_q, head_d, tail_q, tail_d, dec;
  logic       accept, pop;

  imm_decode #(.XLEN(XLEN), .RV64_OPS(RV64_OPS)) u_dec (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .ent_o   (dec)
  );

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_d = dec;
          end else if (accept) begin
            tail_d  = dec;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_imm     = head_q.imm[XLEN-1:0];
  assign out_fmt     = head_q.fmt;
  assign out_is_rel  = head_q.is_rel;
  assign out_target  = head_q.target[XLEN-1:0];
  assign out_illegal = head_q.illegal;

  // Upper halves of the head entry are dead when XLEN is narrower than the record.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{head_q.imm[XLEN_MAX-1:XLEN], head_q.target[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. Accepts a full instruction word plus PC over a valid/ready handshake, and decodes format and sign-extended immediate to XLEN. Also computes a PC-relative target. Results are buffered in a 2-entry skid buffer, so the fetch and execute stages decouple without combinational ready paths through decode.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
RV64_OPS, 0, 1 = decode OP-IMM-32 (opcode[6:2]=00110) as I-type; forced 0 when XLEN=32.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  discard all buffered entries and any same-cycle input
in_valid  in  1  input word valid
in_ready  out  1  buffer can accept (not FULL)
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  imm_fmt_t of head entry
out_is_rel  out  1  target meaningful (B, JAL, AUIPC, C.J, C.BEQZ/C.BNEZ)
out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN
out_illegal  out  1  unrecognised opcode or compressed encoding

Behaviour:
- Reset: state EMPTY; out_valid=0; in_ready=1; out_imm, out_target, out_fmt, out_is_rel and out_illegal all 0.
- Decode (combinational, on in_instr) keys on opcode [6:2] when [1:0]=11:
  - 00100, 00000, 11001, 00110 (RV64_OPS only) -> I-type.
  - 01000 -> S-type.
  - 11000 -> B-type.
  - 11011 -> J-type.
  - 00101, 01101 -> U-type: imm = {instr[31:12],12'b0}, sign-extended to XLEN.
  - Any other opcode -> fmt NONE, imm 0, illegal=1.
- Field slicing follows the RV32I base spec. B/J immediates have bit 0 = 0.
- JALR: out_is_rel=0. out_target is still pc+imm but carries no meaning.
- Compressed input ([1:0]!=11) without RVC_EN: fmt NONE, imm 0, illegal=1.
- Skid buffer: states EMPTY/ONE/FULL, 2 entries, in-order.
  - accept = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready.
  - Transitions:
    - EMPTY + accept -> ONE.
    - ONE + accept & !pop -> FULL.
    - ONE + pop & !accept -> EMPTY.
    - ONE + accept & pop -> ONE (head replaced).
    - FULL + pop -> ONE.
  - in_ready = (state != FULL); registered-state function only, no combinational path from out_ready.
- Latency: accepted in cycle N -> out_valid and data at cycle N+1 when the buffer was EMPTY.
- Outputs remain stable while out_valid && !out_ready.
- flush: next state EMPTY, out_valid=0 next cycle. Flush wins over a same-cycle accept and pop.
- out_target is computed and registered at capture time, not at the head.

Optional Feature:
RVC_EN: when defined, decodes quadrant-01 compressed encodings; all other compressed encodings remain illegal.
- C.ADDI / C.LI (funct3 000/010): imm = sext({i[12],i[6:2]}), fmt CI.
- C.LUI (funct3 011, rd!=0,2): imm = sext({i[12],i[6:2]})<<12, fmt CI.
- C.J (101): fmt CJ, is_rel=1.
- C.BEQZ / C.BNEZ (110/111): fmt CB, is_rel=1.
When undefined, all compressed words are flagged illegal, and the CI/CJ/CB enum values are never produced.

Decomposition:
- Package imm_gen_pkg:
  - imm_fmt_t (3-bit enum: NONE, I, S, B, U, J, CI, CJ/CB share value 7 with is_rel distinguishing not allowed — use CJ=7, CB merged into B).
  - Opcode localparams OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_OP_IMM32.
  - Entry struct {imm, fmt, is_rel, target, illegal}.
- Sub-module imm_decode: purely combinational decode (instr, pc -> entry struct). The top holds only the skid buffer and its FSM.

Test Plan:
- XLEN=32: ADDI 0xFFF00093, pc 0x100, out_ready=1 -> one cycle later imm 0xFFFFFFFF, fmt I, is_rel 0, illegal 0.
- BEQ -4 0xFE000EE3, pc 0x1000 -> imm 0xFFFFFFFC, fmt B, is_rel 1, target 0x00000FFC.
- XLEN=64: LUI 0x800002B7 -> imm 0xFFFFFFFF80000000; LUI 0x123452B7 -> imm 0x0000000012345000.
- Backpressure: out_ready=0, three consecutive valid words -> two accepted, in_ready=0 from third cycle. Then out_ready=1 -> all three delivered in order, none lost or duplicated.
- flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- Word 0x0000007F -> illegal=1, imm 0. Word 0x50FD (C.LI x1,-1): with RVC_EN -> imm 0xFFFFFFFF, fmt CI, illegal 0; without -> illegal 1.
